// File: rtl/oled_tx_scheduler.sv
// SSD1306 traffic sequencer: panel reset, power-up wait, init list, then host
// command bytes and full-frame refreshes fed one byte at a time to the SPI serializer.
module oled_tx_scheduler #(
  parameter int unsigned RESET_CYCLES = 100,
  parameter int unsigned STARTUP_WAIT = 10000000,
  parameter int unsigned FRAME_BYTES  = 1024,
  parameter bit          AUTO_REFRESH = 1'b1,
  localparam int unsigned AW          = $clog2(FRAME_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          panel_rst_n,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_byte,
  output logic          tx_dc,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_byte,
  input  logic          frame_req,
  output logic [AW-1:0] pix_addr,
  input  logic [7:0]    pix_data,
  output logic          init_done,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    RST_PULSE, PWR_WAIT, INIT, IDLE, CMD, FR_HDR, FR_FETCH, FR_SEND
  } state_e;

  localparam logic [31:0]   RST_LAST  = RESET_CYCLES;
  localparam logic [31:0]   WAIT_LAST = STARTUP_WAIT - 1;
  localparam logic [AW-1:0] LAST_PIX  = AW'(FRAME_BYTES - 1);
  localparam logic [4:0]    INIT_LAST = 5'd22;
  localparam logic [4:0]    HDR_LAST  = 5'd5;

  function automatic logic [7:0] initRom(input logic [4:0] idx);
    case (idx)
      5'd0:  initRom = 8'hAE;
      5'd1:  initRom = 8'h81;
      5'd2:  initRom = 8'h7F;
      5'd3:  initRom = 8'hA6;
      5'd4:  initRom = 8'h20;
      5'd5:  initRom = 8'h00;
      5'd6:  initRom = 8'hC8;
      5'd7:  initRom = 8'h40;
      5'd8:  initRom = 8'hA1;
      5'd9:  initRom = 8'hA8;
      5'd10: initRom = 8'h3F;
      5'd11: initRom = 8'hD3;
      5'd12: initRom = 8'h00;
      5'd13: initRom = 8'hD5;
      5'd14: initRom = 8'h80;
      5'd15: initRom = 8'hD9;
      5'd16: initRom = 8'h22;
      5'd17: initRom = 8'hDB;
      5'd18: initRom = 8'h20;
      5'd19: initRom = 8'h8D;
      5'd20: initRom = 8'h14;
      5'd21: initRom = 8'hA4;
      5'd22: initRom = 8'hAF;
      default: initRom = 8'h00;
    endcase
  endfunction

  // Column/page window reset sent ahead of every frame.
  function automatic logic [7:0] hdrRom(input logic [4:0] idx);
    case (idx)
      5'd0: hdrRom = 8'h21;
      5'd1: hdrRom = 8'h00;
      5'd2: hdrRom = 8'h7F;
      5'd3: hdrRom = 8'h22;
      5'd4: hdrRom = 8'h00;
      5'd5: hdrRom = 8'h07;
      default: hdrRom = 8'h00;
    endcase
  endfunction

  state_e        state_q;
  logic [31:0]   cnt_q;
  logic [4:0]    seq_q;
  logic [4:0]    seqNext_d;
  logic [AW-1:0] pixAddr_q;
  logic          txValid_q;
  logic [7:0]    txByte_q;
  logic          txDc_q;
  logic          panelRstN_q;
  logic          cmdReady_q;
  logic          initDone_q;
  logic          busy_q;
  logic          frameDone_q;
  logic          frameReq_q;
  logic          accept;
  logic          latchEn;
  logic          framePending;

  always_comb begin
    seqNext_d    = seq_q + 5'd1;
    accept       = txValid_q & tx_ready;
    latchEn      = state_q inside {IDLE, CMD, FR_HDR, FR_FETCH, FR_SEND};
    framePending = frameReq_q | frame_req | AUTO_REFRESH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RST_PULSE;
      cnt_q       <= '0;
      seq_q       <= '0;
      pixAddr_q   <= '0;
      txValid_q   <= 1'b0;
      txByte_q    <= 8'h00;
      txDc_q      <= 1'b0;
      panelRstN_q <= 1'b0;
      cmdReady_q  <= 1'b0;
      initDone_q  <= 1'b0;
      busy_q      <= 1'b1;
      frameDone_q <= 1'b0;
      frameReq_q  <= 1'b0;
    end else begin
      cmdReady_q  <= 1'b0;
      frameDone_q <= 1'b0;
      if (frame_req && latchEn) frameReq_q <= 1'b1;
      case (state_q)
        RST_PULSE: begin
          if (cnt_q == RST_LAST) begin
            cnt_q       <= '0;
            panelRstN_q <= 1'b1;
            state_q     <= PWR_WAIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        PWR_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cnt_q     <= '0;
            seq_q     <= '0;
            txValid_q <= 1'b1;
            txByte_q  <= initRom(5'd0);
            txDc_q    <= 1'b0;
            state_q   <= INIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        INIT: begin
          if (accept) begin
            if (seq_q == INIT_LAST) begin
              txValid_q  <= 1'b0;
              initDone_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              seq_q    <= seqNext_d;
              txByte_q <= initRom(seqNext_d);
            end
          end
        end
        // The cycle right after a command is consumed still sees the host's
        // cmd_valid, so it must not be taken as a fresh request.
        IDLE: begin
          if (cmd_valid && !cmdReady_q) begin
            txValid_q <= 1'b1;
            txByte_q  <= cmd_byte;
            txDc_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CMD;
          end else if (framePending) begin
            frameReq_q <= 1'b0;
            seq_q      <= '0;
            txValid_q  <= 1'b1;
            txByte_q   <= hdrRom(5'd0);
            txDc_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= FR_HDR;
          end
        end
        CMD: begin
          if (accept) begin
            txValid_q  <= 1'b0;
            cmdReady_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        FR_HDR: begin
          if (accept) begin
            if (seq_q == HDR_LAST) begin
              txValid_q <= 1'b0;
              state_q   <= FR_FETCH;
            end else begin
              seq_q    <= seqNext_d;
              txByte_q <= hdrRom(seqNext_d);
            end
          end
        end
        FR_FETCH: state_q <= FR_SEND;
        // First FR_SEND cycle captures the buffer read issued in FR_FETCH.
        FR_SEND: begin
          if (!txValid_q) begin
            txValid_q <= 1'b1;
            txByte_q  <= pix_data;
            txDc_q    <= 1'b1;
          end else if (tx_ready) begin
            txValid_q <= 1'b0;
            if (pixAddr_q == LAST_PIX) begin
              pixAddr_q   <= '0;
              frameDone_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              pixAddr_q <= pixAddr_q + AW'(1);
              state_q   <= FR_FETCH;
            end
          end
        end
        default: state_q <= RST_PULSE;
      endcase
    end
  end

  assign panel_rst_n = panelRstN_q;
  assign tx_valid    = txValid_q;
  assign tx_byte     = txByte_q;
  assign tx_dc       = txDc_q;
  assign cmd_ready   = cmdReady_q;
  assign pix_addr    = pixAddr_q;
  assign init_done   = initDone_q;
  assign busy        = busy_q;
  assign frame_done  = frameDone_q;

endmodule
